// File: rtl/jtcop_sndlatch_if.sv
// ----------------------------------------------------------------------------
// jtcop_sndlatch_if
//
// Bus bundle between the main-CPU side and the sound command latch.
//
// Signals:
//   main_wr   one-cycle write strobe from the main CPU decoder
//   main_din  command byte written by the main CPU
//   flush     one-cycle: discard queued commands and abort the request
//   snd_ack   one-cycle: sound CPU has read the latch (NMI clear)
//   ovf_clr   one-cycle: clear the sticky overflow flag
//   latch     command byte presented to the sound side
//   snreq     request level, rising edge marks a new command
//   busy      request in flight or commands still queued
//   full      command queue full
//   empty     command queue empty
//   ovf       sticky: a write was dropped
//   timeout   sticky: a request was abandoned
//
// Modports:
//   master  drives the strobes (main CPU / sound side / bench)
//   slave   the latch block itself
// ----------------------------------------------------------------------------
interface jtcop_sndlatch_if;
    logic       main_wr;
    logic [7:0] main_din;
    logic       flush;
    logic       snd_ack;
    logic       ovf_clr;
    logic [7:0] latch;
    logic       snreq;
    logic       busy;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       timeout;

    modport master (
        output main_wr, main_din, flush, snd_ack, ovf_clr,
        input  latch, snreq, busy, full, empty, ovf, timeout
    );

    modport slave (
        input  main_wr, main_din, flush, snd_ack, ovf_clr,
        output latch, snreq, busy, full, empty, ovf, timeout
    );
endinterface

// File: rtl/jtcop_sndlatch.sv
// ----------------------------------------------------------------------------
// jtcop_sndlatch
//
// Main-CPU-side initiator of the sound command interface. Command bytes written
// by the main CPU are queued in a small FIFO and presented one at a time on
// latch/snreq. Each request is held until the sound CPU acknowledges it, then
// snreq is kept low for at least GAP cycles before the next command goes out.
//
// Parameters:
//   AW   FIFO address width, depth = 2**AW
//   GAP  minimum low cycles of snreq between requests (1..255)
//   TOW  request timeout counter width (timeout build only)
//
// Ports:
//   clk     system clock
//   rstn    asynchronous active-low reset
//   bus_io  jtcop_sndlatch_if.slave bundle (strobes in, latch/status out)
//
// Build option:
//   JTCOP_SNDLATCH_TIMEOUT_EN  when defined, a request unacknowledged for
//   2**TOW-1 WAIT cycles is abandoned and the sticky timeout flag is set.
//   When undefined no counter exists and timeout reads 0.
// ----------------------------------------------------------------------------
module jtcop_sndlatch #(
    parameter int unsigned AW  = 3,
    parameter int unsigned GAP = 4,
    parameter int unsigned TOW = 16
) (
    input logic              clk,
    input logic              rstn,
    jtcop_sndlatch_if.slave  bus_io
);

    localparam int unsigned Depth = 2 ** AW;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StGap  = 2'd3;

    localparam logic [7:0] GapLoad = 8'(GAP - 1);

    // Elaboration-time parameter sanity checks
    if (GAP < 1 || GAP > 255) begin : g_bad_gap
        $error("jtcop_sndlatch: GAP must be in 1..255");
    end
    if (TOW < 1) begin : g_bad_tow
        $error("jtcop_sndlatch: TOW must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [Depth];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  state_q, state_d;
    logic        snreq_q, snreq_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  gap_q, gap_d;
    logic        timeout_q, timeout_d;

    logic        push;
    logic        pop;
    logic        drop;

`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [TOW-1:0] to_inc;
    assign to_inc = to_cnt_q + 1'b1;
`endif

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        snreq_d   = snreq_q;
        latch_d   = latch_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        if (bus_io.flush) begin
            // Abort goes through GAP so the low time after a dropped request
            // is still honoured.
            state_d   = StGap;
            snreq_d   = 1'b0;
            gap_d     = GapLoad;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        latch_d = mem_q[rd_ptr_q[AW-1:0]];
                        state_d = StReq;
                    end
                end
                StReq: begin
                    // latch has been stable for a full cycle at this point
                    snreq_d = 1'b1;
                    state_d = StWait;
`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
                StWait: begin
                    if (bus_io.snd_ack) begin
                        snreq_d = 1'b0;
                        gap_d   = GapLoad;
                        state_d = StGap;
                    end
`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
                    else begin
                        to_cnt_d = to_inc;
                        if (&to_inc) begin
                            snreq_d   = 1'b0;
                            timeout_d = 1'b1;
                            gap_d     = GapLoad;
                            state_d   = StGap;
                        end
                    end
`endif
                end
                StGap: begin
                    if (gap_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and flags
    // ------------------------------------------------------------------
    always_comb begin
        // A full queue still accepts a write when the head leaves the same cycle
        push = bus_io.main_wr && !bus_io.flush && (!full_q || pop);
        // Writes swallowed by flush are not overflows
        drop = bus_io.main_wr && !bus_io.flush && !push;

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        if (bus_io.flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        end

        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        // Set beats clear when both happen together
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus_io.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus_io.main_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= StIdle;
            snreq_q   <= 1'b0;
            latch_q   <= 8'd0;
            gap_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            snreq_q   <= snreq_d;
            latch_q   <= latch_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_io.latch   = latch_q;
    assign bus_io.snreq   = snreq_q;
    assign bus_io.busy    = (state_q != StIdle) || !empty_q;
    assign bus_io.full    = full_q;
    assign bus_io.empty   = empty_q;
    assign bus_io.ovf     = ovf_q;
`ifdef JTCOP_SNDLATCH_TIMEOUT_EN
    assign bus_io.timeout = timeout_q;
`else
    assign bus_io.timeout = 1'b0;
`endif

endmodule
